// File: rtl/poly_tone_sequencer.sv
// Multi-channel square-wave note sequencer: steps through a note memory, plays
// NUM_CH square tones with independent half-periods and mixes them into one signed sample.
module poly_tone_sequencer #(
  parameter int NUM_CH  = 2,
  parameter int HALF_W  = 20,
  parameter int ADDR_W  = 10,
  parameter int TEMPO_W = 27,
  parameter int CH_AMP  = 400000000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [ADDR_W-1:0]        last_addr,
  input  logic [TEMPO_W-1:0]       tempo_limit,
  input  logic [TEMPO_W-1:0]       tempo_limit_fast,
  input  logic [ADDR_W-1:0]        tempo_change_addr,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [NUM_CH*HALF_W-1:0] rom_q,
  output logic signed [31:0]       sample_out,
  output logic                     playing,
  output logic                     step_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY} state_t;

  localparam logic signed [31:0] AMP = 32'(CH_AMP);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [TEMPO_W-1:0]  r_step_cnt;
  logic [HALF_W-1:0]   r_half [NUM_CH];
  logic [HALF_W-1:0]   r_cnt  [NUM_CH];
  logic [NUM_CH-1:0]   r_phase;
  logic signed [31:0]  r_sample;
  logic                r_playing;
  logic                r_step_pulse;

  logic [TEMPO_W-1:0]  w_lim;
  logic [TEMPO_W-1:0]  w_lim_m1;
  logic                w_step_end;
  logic                w_at_last;
  logic signed [31:0]  w_mix;

  // Step length follows the address currently playing; a zero limit acts as one cycle.
  always_comb begin
    w_lim      = (r_addr > tempo_change_addr) ? tempo_limit_fast : tempo_limit;
    w_lim_m1   = (w_lim == '0) ? '0 : w_lim - TEMPO_W'(1);
    w_step_end = (r_step_cnt >= w_lim_m1);
    w_at_last  = (r_addr >= last_addr);
  end

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    w_mix = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_half[i] != '0 && ch_enable[i]) begin
        if (r_phase[i]) w_mix = w_mix - AMP;
        else            w_mix = w_mix + AMP;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_step_cnt   <= '0;
      r_phase      <= '0;
      r_sample     <= '0;
      r_playing    <= 1'b0;
      r_step_pulse <= 1'b0;
      // NOTE: the per-channel arrays are plain flops, not a RAM, so they reset like any other state.
      for (int i = 0; i < NUM_CH; i++) begin
        r_half[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      r_step_pulse <= 1'b0;
      if (stop) begin
        r_state   <= S_IDLE;
        r_addr    <= '0;
        r_playing <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_addr   <= '0;
            r_sample <= '0;
            if (start) begin
              r_state   <= S_FETCH;
              r_playing <= 1'b1;
            end
          end
          S_FETCH: r_state <= S_LOAD;
          S_LOAD: begin
            for (int i = 0; i < NUM_CH; i++) begin
              r_half[i] <= rom_q[i*HALF_W +: HALF_W];
              r_cnt[i]  <= '0;
            end
            r_phase    <= '0;
            r_step_cnt <= '0;
            r_state    <= S_PLAY;
          end
          S_PLAY: begin
            r_step_cnt <= r_step_cnt + TEMPO_W'(1);
            r_sample   <= w_mix;
            for (int i = 0; i < NUM_CH; i++) begin
              if (r_half[i] != '0) begin
                if (r_cnt[i] == r_half[i] - HALF_W'(1)) begin
                  r_cnt[i]   <= '0;
                  r_phase[i] <= ~r_phase[i];
                end else begin
                  r_cnt[i] <= r_cnt[i] + HALF_W'(1);
                end
              end
            end
            // >= rather than == so a live tempo decrease cannot strand the step.
            if (w_step_end) begin
              r_step_pulse <= 1'b1;
              if (!w_at_last) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_state <= S_FETCH;
              end else if (loop_en) begin
                r_addr  <= '0;
                r_state <= S_FETCH;
              end else begin
                r_addr    <= '0;
                r_state   <= S_IDLE;
                r_playing <= 1'b0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rom_addr   = r_addr;
  assign sample_out = r_sample;
  assign playing    = r_playing;
  assign step_pulse = r_step_pulse;

endmodule

// File: tb/tb_poly_tone_sequencer.sv
// Directed bench for poly_tone_sequencer: step pulses are checked by a scoreboard
// monitor, samples and status are checked against hand-derived values.
module tb_poly_tone_sequencer;

  localparam int NUM_CH  = 2;
  localparam int HALF_W  = 20;
  localparam int ADDR_W  = 10;
  localparam int TEMPO_W = 27;
  localparam int AMP     = 400000000;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start, stop, loop_en;
  logic [ADDR_W-1:0]        last_addr, tempo_change_addr, rom_addr;
  logic [TEMPO_W-1:0]       tempo_limit, tempo_limit_fast;
  logic [NUM_CH-1:0]        ch_enable;
  logic [NUM_CH*HALF_W-1:0] rom_q;
  logic signed [31:0]       sample_out;
  logic                     playing, step_pulse;

  logic [NUM_CH*HALF_W-1:0] mem [0:(1<<ADDR_W)-1];

  typedef struct {int cyc; int addr;} ev_t;
  ev_t sb_q[$];
  ev_t mon_ev;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

  poly_tone_sequencer #(
    .NUM_CH(NUM_CH), .HALF_W(HALF_W), .ADDR_W(ADDR_W), .TEMPO_W(TEMPO_W), .CH_AMP(AMP)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .last_addr(last_addr), .tempo_limit(tempo_limit), .tempo_limit_fast(tempo_limit_fast),
    .tempo_change_addr(tempo_change_addr), .ch_enable(ch_enable), .rom_addr(rom_addr),
    .rom_q(rom_q), .sample_out(sample_out), .playing(playing), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= mem[rom_addr];

  task automatic check(input string name, input longint act, input longint exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every step_pulse must match the oldest expected pulse.
  always @(negedge clk) begin
    if (step_pulse) begin
      if (sb_q.size() == 0) begin
        check("pulse_pending", sb_q.size(), 1);
      end else begin
        mon_ev = sb_q.pop_front();
        check("pulse_cyc", cyc, mon_ev.cyc);
        check("pulse_addr", rom_addr, mon_ev.addr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_pulse(input int c, input int a);
    ev_t e;
    e.cyc  = c;
    e.addr = a;
    sb_q.push_back(e);
  endtask

  // Returns the edge count at which start was sampled.
  task automatic do_start(output int t0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
  endtask

  // Expected sample after start-edge + k + 1, from phase after edge k (k >= 2).
  function automatic int exp_sample(input int k, input int h0, input int h1, input logic [1:0] en);
    int s;
    s = 0;
    if (h0 != 0 && en[0]) s += (((k - 2) / h0) % 2 != 0) ? -AMP : AMP;
    if (h1 != 0 && en[1]) s += (((k - 2) / h1) % 2 != 0) ? -AMP : AMP;
    return s;
  endfunction

  initial begin
    int t0;
    int tbl [12];
    tbl = '{2, 2, 0, -2, 0, 0, 0, 0, 2, 0, -2, -2};
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    last_addr = '0; tempo_change_addr = '1; tempo_limit = 27'd20; tempo_limit_fast = 27'd20;
    ch_enable = 2'b11;
    tick(3);
    reset = 1'b0;
    check("rst_playing", playing, 0);
    check("rst_sample", sample_out, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_pulse", step_pulse, 0);

    // Reset in the middle of PLAY
    mem[0] = {20'd3, 20'd2};
    do_start(t0);
    wait_until(t0 + 10);
    check("mid_playing", playing, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_playing", playing, 0);
    check("midrst_sample", sample_out, 0);
    check("midrst_addr", rom_addr, 0);
    tick(3);

    // Two-channel chord, single step
    do_start(t0);
    expect_pulse(t0 + 22, 0);
    check("chord_playing", playing, 1);
    for (int m = 3; m <= 14; m++) begin
      wait_until(t0 + m);
      check($sformatf("chord_sample_m%0d", m), sample_out, tbl[m-3] * AMP);
    end
    wait_until(t0 + 23);
    check("chord_end_playing", playing, 0);
    wait_until(t0 + 24);
    check("chord_end_sample", sample_out, 0);
    check("chord_sb_drained", sb_q.size(), 0);

    // Three steps, no loop
    mem[1] = {20'd0, 20'd4};
    mem[2] = {20'd6, 20'd0};
    last_addr = 10'd2; tempo_limit = 27'd10; tempo_limit_fast = 27'd10;
    do_start(t0);
    expect_pulse(t0 + 12, 1);
    expect_pulse(t0 + 24, 2);
    expect_pulse(t0 + 36, 0);
    wait_until(t0 + 37);
    check("seq_end_playing", playing, 0);
    wait_until(t0 + 38);
    check("seq_end_sample", sample_out, 0);
    check("seq_sb_drained", sb_q.size(), 0);

    // Looping, then stop
    loop_en = 1'b1;
    do_start(t0);
    expect_pulse(t0 + 12, 1);
    expect_pulse(t0 + 24, 2);
    expect_pulse(t0 + 36, 0);
    expect_pulse(t0 + 48, 1);
    expect_pulse(t0 + 60, 2);
    wait_until(t0 + 40);
    check("loop_playing", playing, 1);
    wait_until(t0 + 61);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_playing", playing, 0);
    check("stop_addr", rom_addr, 0);
    tick(1);
    check("stop_sample", sample_out, 0);
    check("loop_sb_drained", sb_q.size(), 0);
    loop_en = 1'b0;

    // Two tempos: addresses above 1 run at the fast limit
    mem[3] = {20'd2, 20'd2};
    last_addr = 10'd3; tempo_change_addr = 10'd1; tempo_limit_fast = 27'd4;
    do_start(t0);
    expect_pulse(t0 + 12, 1);
    expect_pulse(t0 + 24, 2);
    expect_pulse(t0 + 30, 3);
    expect_pulse(t0 + 36, 0);
    wait_until(t0 + 40);
    check("tempo_playing", playing, 0);
    check("tempo_sb_drained", sb_q.size(), 0);
    tempo_change_addr = '1; tempo_limit_fast = 27'd10;

    // Rest on ch1, ch0 alone at half-period 5
    mem[0] = {20'd0, 20'd5};
    last_addr = 10'd0; tempo_limit = 27'd30; ch_enable = 2'b01;
    do_start(t0);
    expect_pulse(t0 + 32, 0);
    for (int m = 3; m <= 22; m++) begin
      wait_until(t0 + m);
      check($sformatf("rest_sample_m%0d", m), sample_out, exp_sample(m - 1, 5, 0, 2'b01));
    end
    check("rest_first_neg", exp_sample(7, 5, 0, 2'b01), -AMP);
    wait_until(t0 + 34);
    check("rest_sb_drained", sb_q.size(), 0);

    // Muted ch1 while it still has a tone
    mem[0] = {20'd3, 20'd2};
    tempo_limit = 27'd20; ch_enable = 2'b01;
    do_start(t0);
    expect_pulse(t0 + 22, 0);
    for (int m = 3; m <= 14; m++) begin
      wait_until(t0 + m);
      check($sformatf("mute_sample_m%0d", m), sample_out, exp_sample(m - 1, 2, 3, 2'b01));
    end
    wait_until(t0 + 24);
    check("mute_sb_drained", sb_q.size(), 0);
    ch_enable = 2'b11;

    // start and stop together from IDLE
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_playing0", playing, 0);
    tick(3);
    check("startstop_playing1", playing, 0);
    check("startstop_addr", rom_addr, 0);
    check("final_sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", n_run);
    $fatal(1, "watchdog");
  end

endmodule
